// File: rtl/fir_structs_pkg.sv
// Shared types and defaults for the FIR sample/coefficient writer.
// Coefficient loader states plus default widths used by the writer and its bench.
package fir_structs;

   typedef enum logic {
      COEF_LOAD = 1'b0,
      RUN       = 1'b1
   } coef_state_type;

   localparam int DEF_DATA_W   = 32;
   localparam int DEF_DEPTH    = 8;
   localparam int DEF_NUM_TAPS = 12;

endpackage

// File: rtl/fir_sample_writer_mem.sv
// Sample FIFO storage: DEPTH x DATA_W register array with one write port and a
// combinational read port. Contents are not reset.
module sample_fifo_mem #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fir_sample_writer.sv
// Writer side of the FIR input sample FIFO plus coefficient bank loader.
// Show-ahead head entry for control_fsm; sticky overflow/underflow/dropped flags.
module fir_sample_writer
   import fir_structs::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NUM_TAPS = DEF_NUM_TAPS
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       PushIn,
   input  logic [DATA_W-1:0]          DataIn,
   input  logic                       PushCoef,
   input  logic [DATA_W-1:0]          CoefIn,
   input  logic                       fifoPullOut,
   output logic [DATA_W-1:0]          fifo_dout,
   output logic                       fifo_empty,
   output logic                       fifo_full,
   output logic [NUM_TAPS*DATA_W-1:0] coef_bank,
   output logic                       coef_ready,
   output logic                       overflow,
   output logic                       underflow,
   output logic                       dropped
);

   localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IDX_W  = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

   coef_state_type    state_reg;
   logic [IDX_W-1:0]  coef_idx_reg;
   logic              coef_ready_reg;
   logic [DATA_W-1:0] coef_tap_reg [NUM_TAPS];
   logic [ADDR_W-1:0] wr_ptr_reg;
   logic [ADDR_W-1:0] rd_ptr_reg;
   logic [ADDR_W:0]   count_reg;
   logic              overflow_reg;
   logic              underflow_reg;
   logic              dropped_reg;

   logic              running;
   logic              pop_ok;
   logic              push_try;
   logic              push_ok;
   logic [IDX_W-1:0]  coef_wr_idx;
   logic [DATA_W-1:0] mem_rdata;

   assign fifo_empty = (count_reg == '0);
   assign fifo_full  = (count_reg == (ADDR_W+1)'(DEPTH));

   // A coefficient word always wins over a sample in the same cycle.
   assign running     = (state_reg == RUN);
   assign coef_wr_idx = running ? '0 : coef_idx_reg;
   assign pop_ok      = fifoPullOut && !fifo_empty;
   assign push_try    = PushIn && running && !PushCoef;
   assign push_ok     = push_try && (!fifo_full || pop_ok);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg      <= COEF_LOAD;
         coef_idx_reg   <= '0;
         coef_ready_reg <= 1'b0;
      end else if (PushCoef) begin
         case (state_reg)
            COEF_LOAD: begin
               if (coef_idx_reg == LAST_IDX) begin
                  state_reg      <= RUN;
                  coef_ready_reg <= 1'b1;
                  coef_idx_reg   <= '0;
               end else begin
                  coef_idx_reg <= coef_idx_reg + IDX_W'(1);
               end
            end
            RUN: begin
               state_reg      <= COEF_LOAD;
               coef_idx_reg   <= IDX_W'(1);
               coef_ready_reg <= 1'b0;
            end
            default: state_reg <= COEF_LOAD;
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               coef_tap_reg[gi] <= '0;
            end else if (PushCoef && (coef_wr_idx == IDX_W'(gi))) begin
               coef_tap_reg[gi] <= CoefIn;
            end
         end
         assign coef_bank[gi*DATA_W +: DATA_W] = coef_tap_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
         dropped_reg   <= 1'b0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
         if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + (ADDR_W+1)'(1);
            2'b01:   count_reg <= count_reg - (ADDR_W+1)'(1);
            default: count_reg <= count_reg;
         endcase
         if (push_try && fifo_full && !pop_ok)      overflow_reg  <= 1'b1;
         if (fifoPullOut && fifo_empty)             underflow_reg <= 1'b1;
         if (PushIn && (!running || PushCoef))      dropped_reg   <= 1'b1;
      end
   end

   sample_fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok),
      .waddr (wr_ptr_reg),
      .wdata (DataIn),
      .raddr (rd_ptr_reg),
      .rdata (mem_rdata)
   );

   // Memory is never reset, so hide stale contents while empty.
   assign fifo_dout  = fifo_empty ? '0 : mem_rdata;
   assign coef_ready = coef_ready_reg;
   assign overflow   = overflow_reg;
   assign underflow  = underflow_reg;
   assign dropped    = dropped_reg;

endmodule

// File: tb/tb_fir_sample_writer.sv
// Self-checking bench for fir_sample_writer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_fir_sample_writer;

   localparam int DW = 32;
   localparam int DP = 8;
   localparam int NT = 12;

   logic             clk = 1'b0;
   logic             reset;
   logic             PushIn;
   logic [DW-1:0]    DataIn;
   logic             PushCoef;
   logic [DW-1:0]    CoefIn;
   logic             fifoPullOut;
   logic [DW-1:0]    fifo_dout;
   logic             fifo_empty;
   logic             fifo_full;
   logic [NT*DW-1:0] coef_bank;
   logic             coef_ready;
   logic             overflow;
   logic             underflow;
   logic             dropped;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_bank [NT];
   bit            m_loading;
   bit            m_ready;
   int            m_idx;
   bit            m_ovf, m_unf, m_drop;

   fir_sample_writer #(.DATA_W(DW), .DEPTH(DP), .NUM_TAPS(NT)) dut (
      .clk         (clk),
      .reset       (reset),
      .PushIn      (PushIn),
      .DataIn      (DataIn),
      .PushCoef    (PushCoef),
      .CoefIn      (CoefIn),
      .fifoPullOut (fifoPullOut),
      .fifo_dout   (fifo_dout),
      .fifo_empty  (fifo_empty),
      .fifo_full   (fifo_full),
      .coef_bank   (coef_bank),
      .coef_ready  (coef_ready),
      .overflow    (overflow),
      .underflow   (underflow),
      .dropped     (dropped)
   );

   always #5 clk = ~clk;

   function automatic void model_reset();
      q.delete();
      for (int i = 0; i < NT; i++) m_bank[i] = '0;
      m_loading = 1'b1;
      m_ready   = 1'b0;
      m_idx     = 0;
      m_ovf     = 1'b0;
      m_unf     = 1'b0;
      m_drop    = 1'b0;
   endfunction

   function automatic logic [NT*DW-1:0] model_bank();
      logic [NT*DW-1:0] b;
      for (int i = 0; i < NT; i++) b[i*DW +: DW] = m_bank[i];
      return b;
   endfunction

   function automatic logic [DW-1:0] model_head();
      return (q.size() > 0) ? q[0] : '0;
   endfunction

   // One clock of stimulus; the model applies the same rules at the edge.
   task automatic step(input bit pi, input logic [DW-1:0] di, input bit pc,
                       input logic [DW-1:0] ci, input bit pl);
      bit pop_ok, do_push;
      PushIn = pi; DataIn = di; PushCoef = pc; CoefIn = ci; fifoPullOut = pl;
      @(posedge clk);
      pop_ok  = pl && (q.size() > 0);
      do_push = 1'b0;
      if (pl && q.size() == 0) m_unf = 1'b1;
      if (pi) begin
         if (m_loading || pc)              m_drop = 1'b1;
         else if (q.size() == DP && !pop_ok) m_ovf = 1'b1;
         else                               do_push = 1'b1;
      end
      if (pop_ok)  void'(q.pop_front());
      if (do_push) q.push_back(di);
      if (pc) begin
         if (!m_loading) begin
            m_loading = 1'b1; m_bank[0] = ci; m_idx = 1; m_ready = 1'b0;
         end else begin
            m_bank[m_idx] = ci;
            if (m_idx == NT - 1) begin
               m_loading = 1'b0; m_ready = 1'b1; m_idx = 0;
            end else m_idx++;
         end
      end
      #1;
      PushIn = 1'b0; PushCoef = 1'b0; fifoPullOut = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0; PushIn = 0; DataIn = '0; PushCoef = 0; CoefIn = '0; fifoPullOut = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", fifo_empty); end
      n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", fifo_full); end
      n_checks++; if (fifo_dout !== '0) begin n_fail++; $display("FAIL reset_dout: got %h want 0", fifo_dout); end
      n_checks++; if (coef_bank !== '0) begin n_fail++; $display("FAIL reset_bank: got %h want 0", coef_bank); end
      n_checks++; if ({coef_ready, overflow, underflow, dropped} !== 4'b0) begin
         n_fail++; $display("FAIL reset_flags: got %b want 0000", {coef_ready, overflow, underflow, dropped}); end
      @(negedge clk);
      reset = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_coef_load();
      step(1, 32'h1234, 0, '0, 0);
      n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL load_drop: got %b want 1", dropped); end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL load_drop_empty: got %b want 1", fifo_empty); end
      for (int i = 1; i <= NT; i++) begin
         step(0, '0, 1, DW'(i), 0);
         if (i == NT - 1) begin
            n_checks++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL load_early_ready: got %b want 0", coef_ready); end
         end
      end
      n_checks++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b want 1", coef_ready); end
      n_checks++; if (coef_bank[DW-1:0] !== 32'd1) begin n_fail++; $display("FAIL load_tap0: got %h want 1", coef_bank[DW-1:0]); end
      n_checks++; if (coef_bank[NT*DW-1 -: DW] !== 32'd12) begin n_fail++; $display("FAIL load_tap11: got %h want c", coef_bank[NT*DW-1 -: DW]); end
      n_checks++; if (coef_bank !== model_bank()) begin n_fail++; $display("FAIL load_bank: got %h want %h", coef_bank, model_bank()); end
      $display("test_coef_load done");
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < DP; i++) step(1, 32'hA0 + DW'(i), 0, '0, 0);
      n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", fifo_full); end
      n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL fill_empty: got %b want 0", fifo_empty); end
      for (int i = 0; i < DP; i++) begin
         n_checks++; if (fifo_dout !== 32'hA0 + DW'(i)) begin
            n_fail++; $display("FAIL drain_dout[%0d]: got %h want %h", i, fifo_dout, 32'hA0 + DW'(i)); end
         step(0, '0, 0, '0, 1);
      end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL drain_empty: got %b want 1", fifo_empty); end
      $display("test_fill_drain done");
   endtask

   task automatic test_full_boundary();
      for (int i = 0; i < DP; i++) step(1, 32'hB0 + DW'(i), 0, '0, 0);
      n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL full_no_ovf: got %b want 0", overflow); end
      step(1, 32'hFF, 0, '0, 0);
      n_checks++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL full_ovf: got %b want 1", overflow); end
      n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_stays: got %b want 1", fifo_full); end
      step(1, 32'hFF, 0, '0, 1);
      n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL full_pushpop: got %b want 1", fifo_full); end
      for (int i = 0; i < DP; i++) begin
         n_checks++; if (fifo_dout !== model_head()) begin
            n_fail++; $display("FAIL full_drain[%0d]: got %h want %h", i, fifo_dout, model_head()); end
         if (i == DP - 1) begin
            n_checks++; if (fifo_dout !== 32'hFF) begin n_fail++; $display("FAIL full_tail: got %h want ff", fifo_dout); end
         end
         step(0, '0, 0, '0, 1);
      end
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL full_drained: got %b want 1", fifo_empty); end
      $display("test_full_boundary done");
   endtask

   task automatic test_empty_boundary();
      n_checks++; if (underflow !== 1'b0) begin n_fail++; $display("FAIL empty_no_unf: got %b want 0", underflow); end
      step(0, '0, 0, '0, 1);
      n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL empty_unf: got %b want 1", underflow); end
      step(1, 32'h55, 0, '0, 1);
      n_checks++; if (fifo_empty !== 1'b0) begin n_fail++; $display("FAIL empty_pushpop: got %b want 0", fifo_empty); end
      n_checks++; if (fifo_dout !== 32'h55) begin n_fail++; $display("FAIL empty_dout: got %h want 55", fifo_dout); end
      step(0, '0, 0, '0, 1);
      n_checks++; if (fifo_empty !== 1'b1) begin n_fail++; $display("FAIL empty_count1: got %b want 1", fifo_empty); end
      $display("test_empty_boundary done");
   endtask

   task automatic test_wrap();
      int pushes = 0;
      int guard  = 0;
      while (pushes < 20 && guard < 500) begin
         bit pi, pl;
         pi = (q.size() < 3) ? 1'($urandom_range(0, 1)) : 1'b0;
         pl = (q.size() > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
         if (pi) pushes++;
         step(pi, $urandom, 0, '0, pl);
         guard++;
         n_checks++; if (fifo_dout !== model_head() || fifo_empty !== (q.size() == 0)) begin
            n_fail++; $display("FAIL wrap_head: got %h/%b want %h/%b", fifo_dout, fifo_empty, model_head(), q.size() == 0); end
      end
      n_checks++; if (pushes != 20) begin n_fail++; $display("FAIL wrap_budget: got %0d want 20 pushes", pushes); end
      while (q.size() > 0) begin
         n_checks++; if (fifo_dout !== model_head()) begin
            n_fail++; $display("FAIL wrap_drain: got %h want %h", fifo_dout, model_head()); end
         step(0, '0, 0, '0, 1);
      end
      $display("test_wrap done");
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 39) == 0), $urandom,
              1'($urandom_range(0, 2) == 0));
         n_checks++;
         if (fifo_dout !== model_head() || fifo_empty !== (q.size() == 0) || fifo_full !== (q.size() == DP)
             || coef_ready !== m_ready || coef_bank !== model_bank()
             || {overflow, underflow, dropped} !== {m_ovf, m_unf, m_drop}) begin
            n_fail++;
            $display("FAIL random[%0d]: got dout=%h e=%b f=%b rdy=%b flags=%b want dout=%h e=%b f=%b rdy=%b flags=%b",
                     i, fifo_dout, fifo_empty, fifo_full, coef_ready, {overflow, underflow, dropped},
                     model_head(), q.size() == 0, q.size() == DP, m_ready, {m_ovf, m_unf, m_drop});
         end
      end
      $display("test_random done");
   endtask

   task automatic test_reload_reset();
      while (m_loading) step(0, '0, 1, $urandom, 0);
      while (q.size() > 0) step(0, '0, 0, '0, 1);
      n_checks++; if (coef_ready !== 1'b1) begin n_fail++; $display("FAIL reload_pre_ready: got %b want 1", coef_ready); end
      step(1, 32'h11, 0, '0, 0);
      step(1, 32'h22, 0, '0, 0);
      step(1, 32'h33, 1, 32'h77, 0);
      n_checks++; if (coef_ready !== 1'b0) begin n_fail++; $display("FAIL reload_ready: got %b want 0", coef_ready); end
      n_checks++; if (dropped !== 1'b1) begin n_fail++; $display("FAIL reload_drop: got %b want 1", dropped); end
      n_checks++; if (coef_bank[DW-1:0] !== 32'h77) begin n_fail++; $display("FAIL reload_tap0: got %h want 77", coef_bank[DW-1:0]); end
      n_checks++; if (fifo_dout !== 32'h11) begin n_fail++; $display("FAIL reload_keep: got %h want 11", fifo_dout); end
      step(0, '0, 0, '0, 1);
      n_checks++; if (fifo_dout !== 32'h22) begin n_fail++; $display("FAIL reload_next: got %h want 22", fifo_dout); end
      step(1, 32'h44, 0, '0, 0);
      n_checks++; if (fifo_dout !== 32'h22 || fifo_empty !== 1'b0) begin
         n_fail++; $display("FAIL reload_no_store: got %h/%b want 22/0", fifo_dout, fifo_empty); end
      #2;
      reset = 1'b0;
      #1;
      model_reset();
      n_checks++; if (fifo_empty !== 1'b1 || fifo_full !== 1'b0 || fifo_dout !== '0) begin
         n_fail++; $display("FAIL midreset_fifo: got e=%b f=%b dout=%h want 1 0 0", fifo_empty, fifo_full, fifo_dout); end
      n_checks++; if (coef_bank !== '0) begin n_fail++; $display("FAIL midreset_bank: got %h want 0", coef_bank); end
      n_checks++; if ({coef_ready, overflow, underflow, dropped} !== 4'b0) begin
         n_fail++; $display("FAIL midreset_flags: got %b want 0000", {coef_ready, overflow, underflow, dropped}); end
      @(negedge clk);
      reset = 1'b1;
      step(1, 32'h99, 0, '0, 0);
      n_checks++; if (fifo_empty !== 1'b1 || dropped !== 1'b1) begin
         n_fail++; $display("FAIL postreset_load: got e=%b drop=%b want 1 1", fifo_empty, dropped); end
      $display("test_reload_reset done");
   endtask

   initial begin
      test_reset();
      test_coef_load();
      test_fill_drain();
      test_full_boundary();
      test_empty_boundary();
      test_wrap();
      test_random();
      test_reload_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
